// File: rtl/dacfifo_player_if.sv
// ---------------------------------------------------------------------------
// dacfifo_player_if
//   Bundles the CPU-side and DAC-side signals of the playback FIFO.
//
//   CPU side  : wr, store_data, divisor, enable, flags_clr (to player)
//               full, level, underrun, overflow            (from player)
//   DAC side  : dac_data, dac_strobe                       (from player)
//
//   modport master : the agent that pushes samples and polls status
//   modport slave  : the player itself
// ---------------------------------------------------------------------------
interface dacfifo_player_if #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DIV_WIDTH  = 16
);
  logic                  wr;
  logic [15:0]           store_data;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic [DIV_WIDTH-1:0]  divisor;
  logic                  enable;
  logic [15:0]           dac_data;
  logic                  dac_strobe;
  logic                  underrun;
  logic                  overflow;
  logic                  flags_clr;

  modport master (
    output wr, store_data, divisor, enable, flags_clr,
    input  full, level, dac_data, dac_strobe, underrun, overflow
  );

  modport slave (
    input  wr, store_data, divisor, enable, flags_clr,
    output full, level, dac_data, dac_strobe, underrun, overflow
  );
endinterface

// File: rtl/dacfifo_player.sv
// ---------------------------------------------------------------------------
// dacfifo_player
//   Playback FIFO for a DAC/PWM driver. The CPU pushes 16-bit samples; an
//   internal sample-rate timer pops one sample every divisor+1 clocks and
//   holds it on dac_data, pulsing dac_strobe for one cycle on each update.
//   All 2**DEPTH_LOG2 slots are usable (extra pointer wrap bit). Sticky
//   underrun/overflow flags are cleared by flags_clr.
//
//   Ports
//     clk    : system clock, rising edge
//     reset  : synchronous, active-high
//     bus    : dacfifo_player_if.slave (see interface file for signals)
// ---------------------------------------------------------------------------
module dacfifo_player #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DIV_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  dacfifo_player_if.slave   bus
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [DIV_WIDTH-1:0]  cnt_q,    cnt_d;
  logic [15:0]           dac_data_q,   dac_data_d;
  logic                  dac_strobe_q, dac_strobe_d;
  logic                  underrun_q,   underrun_d;
  logic                  overflow_q,   overflow_d;

  // ---------------------------------------------------------------------
  // Occupancy, judged on pre-edge pointers
  // ---------------------------------------------------------------------
  logic empty;
  logic full;
  logic tick;
  logic push;
  logic pop;

  // Extra MSB distinguishes a full ring from an empty one when the low
  // bits of the pointers coincide.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // Timer fires on the cycle the down-counter sits at zero while enabled.
  assign tick = bus.enable && (cnt_q == '0);

  // A write into a full buffer is dropped even if a pop happens on the same
  // edge, and a pop never sees a sample written on the same edge.
  assign push = bus.wr && !full;
  assign pop  = tick && !empty;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    dac_data_d   = dac_data_q;
    dac_strobe_d = 1'b0;
    underrun_d   = underrun_q;
    overflow_d   = overflow_q;

    // Sample-rate timer: hold at divisor while disabled so the first tick
    // after enabling comes divisor+1 cycles later; a new divisor is only
    // picked up at a reload.
    if (!bus.enable) begin
      cnt_d = bus.divisor;
    end else if (cnt_q == '0) begin
      cnt_d = bus.divisor;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      dac_data_d   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      dac_strobe_d = 1'b1;
    end

    // Sticky flags: a set event in the same cycle as flags_clr wins.
    if (bus.flags_clr) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    if (tick && empty) begin
      underrun_d = 1'b1;
    end
    if (bus.wr && full) begin
      overflow_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      dac_data_q   <= '0;
      dac_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      dac_data_q   <= dac_data_d;
      dac_strobe_q <= dac_strobe_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------
  // NOTE: the buffer array has no reset; resetting the pointers already
  // makes every slot unreadable, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.store_data;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.full       = full;
  assign bus.level      = wr_ptr_q - rd_ptr_q;
  assign bus.dac_data   = dac_data_q;
  assign bus.dac_strobe = dac_strobe_q;
  assign bus.underrun   = underrun_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_dacfifo_player.sv
// ---------------------------------------------------------------------------
// tb_dacfifo_player
//   Drives dacfifo_player through directed scenarios and a randomized phase,
//   comparing every output after every clock against a queue-based model.
// ---------------------------------------------------------------------------
module tb_dacfifo_player;

  localparam int DEPTH_LOG2 = 3;
  localparam int DIV_WIDTH  = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk;
  logic reset;

  dacfifo_player_if #(.DEPTH_LOG2(DEPTH_LOG2), .DIV_WIDTH(DIV_WIDTH)) bus ();

  dacfifo_player #(.DEPTH_LOG2(DEPTH_LOG2), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_q [$];
  int          m_cnt;
  logic [15:0] m_dac;
  logic        m_strobe;
  logic        m_und;
  logic        m_ovf;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied,
  // let the DUT take the same edge, then compare all outputs.
  task automatic step();
    bit was_full, was_empty, fire;
    if (reset) begin
      m_q.delete();
      m_cnt    = 0;
      m_dac    = 16'h0000;
      m_strobe = 1'b0;
      m_und    = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      fire      = bus.enable && (m_cnt == 0);

      if (!bus.enable || m_cnt == 0) m_cnt = int'(bus.divisor);
      else                           m_cnt = m_cnt - 1;

      m_strobe = 1'b0;
      if (fire && !was_empty) begin
        m_dac    = m_q.pop_front();
        m_strobe = 1'b1;
      end
      if (bus.wr && !was_full) m_q.push_back(bus.store_data);

      if (bus.flags_clr) begin
        m_und = 1'b0;
        m_ovf = 1'b0;
      end
      if (fire && was_empty)    m_und = 1'b1;
      if (bus.wr && was_full)   m_ovf = 1'b1;
    end

    @(posedge clk);
    #1;
    check("level",      32'(bus.level),      32'(m_q.size()));
    check("full",       32'(bus.full),       32'(m_q.size() == DEPTH));
    check("dac_data",   32'(bus.dac_data),   32'(m_dac));
    check("dac_strobe", 32'(bus.dac_strobe), 32'(m_strobe));
    check("underrun",   32'(bus.underrun),   32'(m_und));
    check("overflow",   32'(bus.overflow),   32'(m_ovf));
  endtask

  task automatic idle_inputs();
    bus.wr        = 1'b0;
    bus.store_data = 16'h0000;
    bus.flags_clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    bus.wr         = 1'b1;
    bus.store_data = d;
    step();
    bus.wr         = 1'b0;
  endtask

  initial begin
    int strobes;
    reset       = 1'b1;
    bus.enable  = 1'b0;
    bus.divisor = 16'd3;
    idle_inputs();
    m_cnt = 0;
    #2;

    // 1: fill to full with playback disabled
    do_reset();
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_dac",   32'(bus.dac_data), 32'd0);
    for (int i = 1; i <= 8; i++) push(16'(i * 16'h1111));
    check("t1_full",  32'(bus.full),  32'd1);
    check("t1_level", 32'(bus.level), 32'd8);
    check("t1_dac",   32'(bus.dac_data), 32'h0000);

    // 2: write into full buffer is dropped, then flags cleared
    push(16'hDEAD);
    check("t2_ovf",   32'(bus.overflow), 32'd1);
    check("t2_level", 32'(bus.level),    32'd8);
    bus.flags_clr = 1'b1;
    step();
    bus.flags_clr = 1'b0;
    check("t2_clr",   32'(bus.overflow), 32'd0);

    // 3: divisor 3 -> one strobe per 4 clocks, drain then underrun
    bus.divisor = 16'd3;
    bus.enable  = 1'b1;
    strobes     = 0;
    for (int c = 0; c < 38; c++) begin
      step();
      if (bus.dac_strobe) strobes++;
    end
    check("t3_strobes", 32'(strobes), 32'd8);
    check("t3_und",     32'(bus.underrun), 32'd1);
    check("t3_dac",     32'(bus.dac_data), 32'h8888);

    // 4: divisor 0, steady-state streaming with 4 entries
    bus.enable  = 1'b0;
    bus.divisor = 16'd0;
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h4000 + 16'(i));
    bus.enable = 1'b1;
    for (int i = 4; i < 20; i++) push(16'h4000 + 16'(i));
    check("t4_level", 32'(bus.level), 32'd4);
    check("t4_und",   32'(bus.underrun), 32'd0);
    check("t4_ovf",   32'(bus.overflow), 32'd0);

    // 5: drain, then flags_clr held while underrun ticks keep firing
    for (int c = 0; c < 6; c++) step();
    bus.flags_clr = 1'b1;
    for (int c = 0; c < 3; c++) step();
    bus.flags_clr = 1'b0;
    check("t5_und", 32'(bus.underrun), 32'd1);

    // 6: reset mid-operation with 5 queued samples and the timer running
    bus.enable  = 1'b0;
    bus.divisor = 16'd5;
    do_reset();
    for (int i = 0; i < 5; i++) push(16'h6000 + 16'(i));
    bus.enable = 1'b1;
    step();
    do_reset();
    check("t6_level", 32'(bus.level),    32'd0);
    check("t6_dac",   32'(bus.dac_data), 32'd0);
    check("t6_und0",  32'(bus.underrun), 32'd0);
    step();
    check("t6_und1",  32'(bus.underrun), 32'd1);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.wr         = ($urandom_range(0, 99) < 45);
      bus.store_data = 16'($urandom);
      bus.flags_clr  = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 5)  bus.divisor = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 4)  bus.enable  = ~bus.enable;
      step();
    end
    reset = 1'b0;
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
